// File: rtl/bip_control_unit.sv
// bip_control_unit: FETCH/DECODE/EXEC sequencer for the BIP accumulator CPU
//
// Ports:
//   i_clock, i_reset  clock and synchronous active-high reset
//   i_start           leaves IDLE and starts fetching from PC
//   i_instruction     program memory data, one cycle after o_pc_addr
//   o_pc_addr         program memory address (PC)
//   o_operand         IR operand field for the datapath sign extender
//   o_sel_a, o_sel_b, o_enb_acc, o_operation  datapath controls
//   o_data_addr, o_data_rd, o_data_wr         data memory interface
//   o_busy, o_halt, o_illegal, o_instr_count  status
module bip_control_unit #(
    parameter NB_INSTRUCTION = 16,
    parameter NB_OPCODE      = 5,
    parameter NB_ADDR        = 11,
    parameter NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic [NB_ADDR-1:0]        o_pc_addr,
    output logic [NB_OPERAND-1:0]     o_operand,
    output logic [1:0]                o_sel_a,
    output logic                      o_sel_b,
    output logic                      o_enb_acc,
    output logic                      o_operation,
    output logic [NB_ADDR-1:0]        o_data_addr,
    output logic                      o_data_rd,
    output logic                      o_data_wr,
    output logic                      o_busy,
    output logic                      o_halt,
    output logic                      o_illegal,
    output logic [NB_INSTRUCTION-1:0] o_instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'd0;
    localparam logic [NB_OPCODE-1:0] OP_STO  = 5'd1;
    localparam logic [NB_OPCODE-1:0] OP_LD   = 5'd2;
    localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'd3;
    localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'd4;
    localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'd5;
    localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'd6;
    localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'd7;

    state_t                      state, next_state;
    logic [NB_ADDR-1:0]          pc;
    logic [NB_INSTRUCTION-1:0]   ir;
    logic [NB_INSTRUCTION-1:0]   instr_count;
    logic [NB_OPCODE-1:0]        opcode, in_opcode;

    assign opcode        = ir[NB_INSTRUCTION-1:NB_OPERAND];
    assign in_opcode     = i_instruction[NB_INSTRUCTION-1:NB_OPERAND];
    assign o_pc_addr     = pc;
    assign o_operand     = ir[NB_OPERAND-1:0];
    // DECODE addresses the operand fetch before IR is loaded
    assign o_data_addr   = (state == DECODE) ? i_instruction[NB_ADDR-1:0] : ir[NB_ADDR-1:0];
    assign o_instr_count = instr_count;
    assign o_busy        = !i_reset && (state == FETCH || state == DECODE || state == EXEC);
    assign o_halt        = !i_reset && (state == HALT);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE)
                ir <= i_instruction;
            if (state == EXEC) begin
                if (opcode != OP_HLT)
                    pc <= pc + 1'b1;
                if (instr_count != '1)
                    instr_count <= instr_count + 1'b1;
            end
        end
    end

    // Gating everything on i_reset keeps an in-flight EXEC from strobing the datapath
    always_comb begin
        next_state  = state;
        o_sel_a     = 2'b11;
        o_sel_b     = 1'b0;
        o_operation = 1'b1;
        o_enb_acc   = 1'b0;
        o_data_wr   = 1'b0;
        o_data_rd   = 1'b0;
        o_illegal   = 1'b0;
        if (!i_reset) begin
            case (state)
                IDLE:   next_state = i_start ? FETCH : IDLE;
                FETCH:  next_state = DECODE;
                DECODE: begin
                    next_state = EXEC;
                    o_data_rd  = (in_opcode == OP_LD) || (in_opcode == OP_ADD) || (in_opcode == OP_SUB);
                end
                EXEC: begin
                    next_state = (opcode == OP_HLT) ? HALT : FETCH;
                    case (opcode)
                        OP_HLT:  ;
                        OP_STO:  o_data_wr = 1'b1;
                        OP_LD:   begin o_sel_a = 2'b00; o_enb_acc = 1'b1; end
                        OP_LDI:  begin o_sel_a = 2'b01; o_enb_acc = 1'b1; end
                        OP_ADD:  begin o_sel_a = 2'b10; o_sel_b = 1'b1; o_enb_acc = 1'b1; end
                        OP_ADDI: begin o_sel_a = 2'b10; o_enb_acc = 1'b1; end
                        OP_SUB:  begin o_sel_a = 2'b10; o_sel_b = 1'b1; o_operation = 1'b0; o_enb_acc = 1'b1; end
                        OP_SUBI: begin o_sel_a = 2'b10; o_operation = 1'b0; o_enb_acc = 1'b1; end
                        default: o_illegal = 1'b1;
                    endcase
                end
                HALT:    next_state = HALT;
                default: next_state = IDLE;
            endcase
        end
    end
endmodule
